// File: rtl/arq_sched.sv
// rtl/arq_sched.sv - ARQ replay scheduler: send / wait-for-ACK / replay / fail sequencing.
// Statistics counters are built only when ARQ_SCHED_STATS_EN is defined.
module arq_sched #(
  parameter int unsigned TIMEOUT_TICKS = 4096,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_frame_start,
  input  logic        i_frame_done,
  input  logic        i_ack_valid,
  input  logic        i_ack_good,
  input  logic        i_arq_en,
  input  logic        i_retrans_en,
  output logic        o_read_line_fifo,
  output logic        o_retrans_req,
  output logic        o_send_complete,
  output logic        o_retrans_wait,
  output logic        o_fail,
  output logic [2:0]  o_state,
  output logic [3:0]  o_retry_cnt,
  output logic [15:0] o_nak_cnt,
  output logic [15:0] o_timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_HOLD     = 3'd3,
    S_REPLAY   = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  MAX_R   = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic        fail_q, fail_d;
  logic        read_q, rreq_q, sc_q, wait_q;
  logic        ack_ev, nak_ev, to_ev;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    ack_ev  = i_ack_valid & i_ack_good;
    nak_ev  = i_ack_valid & ~i_ack_good;
    // Timeout fires on the tick that would bring the timer to TIMEOUT_TICKS.
    to_ev   = (state_q == S_WAIT_ACK) && i_tick && (timer_q == TO_LAST);
    case (state_q)
      S_IDLE: if (i_frame_start) begin
        state_d = S_SEND;
        retry_d = 4'd0;
        fail_d  = 1'b0;
      end
      S_SEND: if (i_frame_done) begin
        if (i_arq_en) begin
          state_d = S_WAIT_ACK;
          timer_d = 16'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT_ACK: begin
        if (i_tick) timer_d = timer_q + 16'd1;
        if (!i_arq_en || ack_ev)     state_d = S_DONE;
        else if (nak_ev || to_ev) begin
          if (retry_q == MAX_R)      state_d = S_FAIL;
          else if (i_retrans_en)     state_d = S_REPLAY;
          else                       state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!i_arq_en)         state_d = S_DONE;
        else if (i_retrans_en) state_d = S_REPLAY;
      end
      S_REPLAY: if (i_frame_done) begin
        state_d = S_WAIT_ACK;
        timer_d = 16'd0;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REPLAY && state_q != S_REPLAY) retry_d = retry_q + 4'd1;
    if (state_d == S_FAIL) fail_d = 1'b1;
  end

  // Outputs are registered from the next state so they line up with o_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      timer_q <= 16'd0;
      retry_q <= 4'd0;
      fail_q  <= 1'b0;
      read_q  <= 1'b0;
      rreq_q  <= 1'b0;
      sc_q    <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      read_q  <= (state_d == S_REPLAY);
      rreq_q  <= (state_d == S_REPLAY) && (state_q != S_REPLAY);
      sc_q    <= (state_d == S_DONE) || (state_d == S_FAIL);
      wait_q  <= (state_d == S_HOLD);
    end
  end

`ifdef ARQ_SCHED_STATS_EN
  logic [15:0] nak_cnt_q, to_cnt_q;
  logic        nak_acc, to_acc;

  assign nak_acc = (state_q == S_WAIT_ACK) && i_arq_en && nak_ev;
  assign to_acc  = to_ev && i_arq_en && !ack_ev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      nak_cnt_q <= 16'd0;
      to_cnt_q  <= 16'd0;
    end else begin
      if (nak_acc && nak_cnt_q != 16'hFFFF) nak_cnt_q <= nak_cnt_q + 16'd1;
      if (to_acc && to_cnt_q != 16'hFFFF)   to_cnt_q  <= to_cnt_q + 16'd1;
    end
  end

  assign o_nak_cnt     = nak_cnt_q;
  assign o_timeout_cnt = to_cnt_q;
`else
  assign o_nak_cnt     = 16'd0;
  assign o_timeout_cnt = 16'd0;
`endif

  assign o_state          = state_q;
  assign o_retry_cnt      = retry_q;
  assign o_fail           = fail_q;
  assign o_read_line_fifo = read_q;
  assign o_retrans_req    = rreq_q;
  assign o_send_complete  = sc_q;
  assign o_retrans_wait   = wait_q;

endmodule

// File: tb/tb_arq_sched.sv
// tb/tb_arq_sched.sv - directed self-checking bench for arq_sched (TIMEOUT_TICKS=4, MAX_RETRY=3).
module tb_arq_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0, tick = 1'b0, fstart = 1'b0, fdone = 1'b0;
  logic        ack_v = 1'b0, ack_g = 1'b0, arq_en = 1'b0, rt_en = 1'b0;
  logic        rd_fifo, rt_req, sc, rt_wait, fail;
  logic [2:0]  state;
  logic [3:0]  retry;
  logic [15:0] nak_cnt, to_cnt;

  int checks = 0;
  int errors = 0;
  int sc_pulses = 0;
  int rr_pulses = 0;
  int sc_base, rr_base;
  logic [15:0] exp_to;

  arq_sched #(.TIMEOUT_TICKS(4), .MAX_RETRY(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_frame_start(fstart),
    .i_frame_done(fdone), .i_ack_valid(ack_v), .i_ack_good(ack_g),
    .i_arq_en(arq_en), .i_retrans_en(rt_en),
    .o_read_line_fifo(rd_fifo), .o_retrans_req(rt_req), .o_send_complete(sc),
    .o_retrans_wait(rt_wait), .o_fail(fail), .o_state(state),
    .o_retry_cnt(retry), .o_nak_cnt(nak_cnt), .o_timeout_cnt(to_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (sc)     sc_pulses++;
    if (rt_req) rr_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(); fstart = 1'b1; step(); fstart = 1'b0; endtask
  task automatic pulse_done();  fdone  = 1'b1; step(); fdone  = 1'b0; endtask
  task automatic pulse_tick();  tick   = 1'b1; step(); tick   = 1'b0; endtask
  task automatic pulse_ack(input logic good);
    ack_v = 1'b1; ack_g = good; step(); ack_v = 1'b0; ack_g = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {13'd0, state}, 16'd0);
    chk({tag, "_outs"}, {11'd0, rd_fifo, rt_req, sc, rt_wait, fail}, 16'd0);
    chk({tag, "_retry"}, {12'd0, retry}, 16'd0);
    chk({tag, "_nak"}, nak_cnt, 16'd0);
    chk({tag, "_to"}, to_cnt, 16'd0);
  endtask

  initial begin
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk_all_zero("reset");

    // arq disabled: SEND -> DONE -> IDLE
    sc_base = sc_pulses;
    pulse_start();
    chk("s1_send", {13'd0, state}, 16'd1);
    pulse_done();
    chk("s1_done", {13'd0, state}, 16'd5);
    chk("s1_sc", {15'd0, sc}, 16'd1);
    step();
    chk("s1_idle", {13'd0, state}, 16'd0);
    chk("s1_sc_pulses", 16'(sc_pulses - sc_base), 16'd1);
    chk("s1_retry", {12'd0, retry}, 16'd0);

    // NAK after 2 ticks, immediate replay, then ACK
    arq_en = 1'b1; rt_en = 1'b1;
    sc_base = sc_pulses; rr_base = rr_pulses;
    pulse_start(); pulse_done();
    chk("s2_wait", {13'd0, state}, 16'd2);
    pulse_tick(); pulse_tick();
    pulse_ack(1'b0);
    chk("s2_replay", {13'd0, state}, 16'd4);
    chk("s2_rreq", {15'd0, rt_req}, 16'd1);
    chk("s2_retry", {12'd0, retry}, 16'd1);
    chk("s2_rdfifo", {15'd0, rd_fifo}, 16'd1);
    step();
    chk("s2_rreq_off", {15'd0, rt_req}, 16'd0);
    chk("s2_rdfifo_hold", {15'd0, rd_fifo}, 16'd1);
    pulse_done();
    chk("s2_wait2", {13'd0, state}, 16'd2);
    chk("s2_rdfifo_off", {15'd0, rd_fifo}, 16'd0);
    pulse_ack(1'b1);
    chk("s2_done", {13'd0, state}, 16'd5);
    step();
    chk("s2_sc_pulses", 16'(sc_pulses - sc_base), 16'd1);
    chk("s2_rr_pulses", 16'(rr_pulses - rr_base), 16'd1);

    // four timeouts: three replays then FAIL
    sc_base = sc_pulses;
    pulse_start(); pulse_done();
    for (int r = 1; r <= 3; r++) begin
      for (int t = 0; t < 4; t++) pulse_tick();
      chk($sformatf("s3_replay%0d", r), {13'd0, state}, 16'd4);
      chk($sformatf("s3_retry%0d", r), {12'd0, retry}, 16'(r));
      pulse_done();
    end
    for (int t = 0; t < 4; t++) pulse_tick();
    chk("s3_failstate", {13'd0, state}, 16'd6);
    chk("s3_fail", {15'd0, fail}, 16'd1);
    chk("s3_retry_max", {12'd0, retry}, 16'd3);
    step();
    chk("s3_idle", {13'd0, state}, 16'd0);
    chk("s3_fail_sticky", {15'd0, fail}, 16'd1);
    chk("s3_sc_pulses", 16'(sc_pulses - sc_base), 16'd1);
`ifdef ARQ_SCHED_STATS_EN
    exp_to = 16'd4;
`else
    exp_to = 16'd0;
`endif
    chk("s3_to_cnt", to_cnt, exp_to);

    // replay withheld: HOLD for 10 cycles, then REPLAY
    rt_en = 1'b0;
    pulse_start();
    chk("s4_fail_clr", {15'd0, fail}, 16'd0);
    pulse_done();
    pulse_ack(1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("s4_hold%0d", i), {12'd0, state, rt_wait}, 16'h7);
      step();
    end
    rt_en = 1'b1;
    step();
    chk("s4_replay", {13'd0, state}, 16'd4);
    chk("s4_wait_off", {15'd0, rt_wait}, 16'd0);
    chk("s4_retry", {12'd0, retry}, 16'd1);
    pulse_done(); pulse_ack(1'b1); step();

    // ACK coincides with the timeout tick: ACK wins
    pulse_start(); pulse_done();
    for (int t = 0; t < 3; t++) pulse_tick();
    tick = 1'b1; ack_v = 1'b1; ack_g = 1'b1;
    step();
    tick = 1'b0; ack_v = 1'b0; ack_g = 1'b0;
    chk("s5_done", {13'd0, state}, 16'd5);
    chk("s5_retry", {12'd0, retry}, 16'd0);
    chk("s5_to_cnt", to_cnt, exp_to);
    step();

    // reset during REPLAY aborts silently
    pulse_start(); pulse_done(); pulse_ack(1'b0);
    chk("s6_replay", {13'd0, state}, 16'd4);
    sc_base = sc_pulses;
    rst = 1'b1; step(); rst = 1'b0;
    chk_all_zero("s6_rst");
    step();
    chk("s6_no_sc", 16'(sc_pulses - sc_base), 16'd0);
    pulse_start();
    chk("s6_send", {13'd0, state}, 16'd1);
    chk("s6_nak_cnt", nak_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
